// File: rtl/uart_rx_oversampled.sv
// 8N1 serial receiver with 16x oversampling and mid-bit sampling.
// Emits one-cycle rx_done / frame_err strobes and waits out held-low break conditions.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | counting to the middle of the start bit; high there means a glitch
// DATA      | sampling DBIT data bits, LSB first, at mid-bit
// STOP      | sampling the stop bit at SB_TICK-1
// WAIT_HIGH | stop bit was low; hold until the line returns high (break)
module uart_rx_oversampled #(
  parameter int TICK_DIV = 163,
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] d_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [2:0]    N_LAST    = 3'(DBIT - 1);
  localparam logic [3:0]    SB_LAST   = 4'(SB_TICK - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state, state_n;
  logic          rx_q1, rx_s;
  logic [TW-1:0] tick_cnt;
  logic          s_tick, tick_clr;
  logic [3:0]    s_cnt, s_cnt_n;
  logic [2:0]    n, n_n;
  logic [7:0]    b, b_n;
  logic [7:0]    d_out_n;
  logic          rx_done_n, frame_err_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  assign s_tick = (tick_cnt == TICK_LAST);

  // Clearing on the start edge puts the 8th tick in the middle of the start bit.
  always_ff @(posedge clk) begin
    if (reset)                  tick_cnt <= '0;
    else if (tick_clr || s_tick) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s_cnt     <= 4'd0;
      n         <= 3'd0;
      b         <= 8'h00;
      d_out     <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      s_cnt     <= s_cnt_n;
      n         <= n_n;
      b         <= b_n;
      d_out     <= d_out_n;
      rx_done   <= rx_done_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    s_cnt_n     = s_cnt;
    n_n         = n;
    b_n         = b;
    d_out_n     = d_out;
    rx_done_n   = 1'b0;
    frame_err_n = 1'b0;
    tick_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n  = START;
          s_cnt_n  = 4'd0;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == 4'd7) begin
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = 4'd0;
              n_n     = 3'd0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == 4'd15) begin
            b_n     = {rx_s, b[7:1]};
            s_cnt_n = 4'd0;
            if (n == N_LAST) state_n = STOP;
            else             n_n     = n + 3'd1;
          end else begin
            s_cnt_n = s_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == SB_LAST) begin
            if (rx_s) begin
              d_out_n   = b;
              rx_done_n = 1'b1;
              state_n   = IDLE;
            end else begin
              frame_err_n = 1'b1;
              state_n     = WAIT_HIGH;
            end
          end else begin
            s_cnt_n = s_cnt + 4'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled at TICK_DIV=4 (64 clk per bit).
// Expected bytes are queued as frames are driven and popped on every rx_done.
module tb_uart_rx_oversampled;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] d_out;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  uart_rx_oversampled #(.TICK_DIV(4), .DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .d_out(d_out),
    .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int n_checks = 0, n_pass = 0;
  int done_cnt = 0, ferr_cnt = 0, busy_seen = 0;
  int last_done_cyc = 0, prev_done_cyc = 0, t_fall = 0;

  always @(negedge clk) begin
    if (rx_done || frame_err) begin
      n_checks++;
      if (rx_done && frame_err) $display("FAIL strobe_overlap: rx_done=1 frame_err=1, required not both");
      else n_pass++;
    end
    if (rx_done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_rx_done: d_out=%h with no byte expected", d_out);
      end else begin
        exp_b = exp_q.pop_front();
        if (d_out !== exp_b) $display("FAIL scoreboard_byte: d_out=%h required %h", d_out, exp_b);
        else n_pass++;
      end
    end
    if (frame_err) ferr_cnt++;
    if (busy) busy_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(BIT);
  endtask

  task automatic send_byte(input logic [7:0] val, input logic stop_bit, input bit push);
    if (push) exp_q.push_back(val);
    t_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(val[i]);
    drive_bit(stop_bit);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    idle(3);
    reset = 1'b0;
    n_checks++;
    if (d_out !== 8'h00) $display("FAIL reset_d_out: got %h required 00", d_out); else n_pass++;
    n_checks++;
    if (rx_done !== 1'b0) $display("FAIL reset_rx_done: got %b required 0", rx_done); else n_pass++;
    n_checks++;
    if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b required 0", frame_err); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    idle(20);
  endtask

  task automatic test_basic;
    int d0, f0, lat;
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, 1'b1, 1'b1);
    idle(20);
    lat = last_done_cyc - t_fall;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); else n_pass++;
    n_checks++;
    if (ferr_cnt != f0) $display("FAIL basic_frame_err: got %0d pulses required 0", ferr_cnt - f0); else n_pass++;
    n_checks++;
    if (d_out !== 8'hA5) $display("FAIL basic_d_out: got %h required a5", d_out); else n_pass++;
    n_checks++;
    if (lat < 606 || lat > 614) $display("FAIL basic_latency: got %0d required 610+-4", lat); else n_pass++;
  endtask

  task automatic test_glitch;
    int d0, f0, b0;
    d0 = done_cnt; f0 = ferr_cnt; b0 = busy_seen;
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(100);
    n_checks++;
    if (busy_seen == b0) $display("FAIL glitch_busy: got 0 busy cycles required >0"); else n_pass++;
    n_checks++;
    if (done_cnt != d0 || ferr_cnt != f0)
      $display("FAIL glitch_strobes: got rx_done=%0d frame_err=%0d required 0/0", done_cnt - d0, ferr_cnt - f0);
    else n_pass++;
    n_checks++;
    if (d_out !== 8'hA5) $display("FAIL glitch_d_out: got %h required a5", d_out); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL glitch_idle: busy got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(100);
      n_checks++;
      if (d_out !== 8'hA5) $display("FAIL break_d_out: got %h required a5 at sample %0d", d_out, i); else n_pass++;
    end
    rx = 1'b1;
    idle(50);
    n_checks++;
    if (ferr_cnt - f0 != 1) $display("FAIL break_frame_err_count: got %0d required 1", ferr_cnt - f0); else n_pass++;
    n_checks++;
    if (done_cnt != d0) $display("FAIL break_no_done: got %0d rx_done required 0", done_cnt - d0); else n_pass++;
    send_byte(8'h01, 1'b1, 1'b1);
    idle(20);
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL after_break_done: got %0d required 1", done_cnt - d0); else n_pass++;
    n_checks++;
    if (d_out !== 8'h01) $display("FAIL after_break_d_out: got %h required 01", d_out); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int d0, gap;
    d0 = done_cnt;
    send_byte(8'h00, 1'b1, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    idle(20);
    gap = last_done_cyc - prev_done_cyc;
    n_checks++;
    if (done_cnt - d0 != 2) $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0); else n_pass++;
    n_checks++;
    if (gap < 636 || gap > 644) $display("FAIL b2b_spacing: got %0d required 640+-4", gap); else n_pass++;
    n_checks++;
    if (d_out !== 8'hFF) $display("FAIL b2b_d_out: got %h required ff", d_out); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int d0, f0;
    logic [7:0] v;
    v = 8'h77;
    d0 = done_cnt; f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(v[i]);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    rx = 1'b1;
    n_checks++;
    if (d_out !== 8'h00) $display("FAIL midreset_d_out: got %h required 00", d_out); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL midreset_busy: got %b required 0", busy); else n_pass++;
    idle(200);
    n_checks++;
    if (done_cnt != d0 || ferr_cnt != f0)
      $display("FAIL midreset_strobes: got rx_done=%0d frame_err=%0d required 0/0", done_cnt - d0, ferr_cnt - f0);
    else n_pass++;
    send_byte(8'h5A, 1'b1, 1'b1);
    idle(20);
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL midreset_next_done: got %0d required 1", done_cnt - d0); else n_pass++;
    n_checks++;
    if (d_out !== 8'h5A) $display("FAIL midreset_next_d_out: got %h required 5a", d_out); else n_pass++;
  endtask

  task automatic test_low_through_reset;
    int d0;
    d0 = done_cnt;
    reset = 1'b1;
    rx = 1'b0;
    idle(5);
    reset = 1'b0;
    idle(800);
    rx = 1'b1;
    idle(100);
    n_checks++;
    if (done_cnt != d0) $display("FAIL low_reset_spurious: got %0d rx_done required 0", done_cnt - d0); else n_pass++;
    send_byte(8'hC3, 1'b1, 1'b1);
    idle(20);
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL low_reset_done: got %0d required 1", done_cnt - d0); else n_pass++;
    n_checks++;
    if (d_out !== 8'hC3) $display("FAIL low_reset_d_out: got %h required c3", d_out); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d bytes left required 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_low_through_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
